press_event_decoder: RTL and testbench

Classifies button activity into single-cycle event pulses: short press, double press, long press and auto-repeat while held. Sits directly downstream of `long_press_detect` and consumes its synchronised button level and its long-press level. Drives the UI/menu control logic, which needs discrete events rather than raw levels.

---
 rtl/press_event_decoder.sv | 157 +++++++++++++++
 tb/tb_press_event_decoder.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/press_event_decoder.sv
// Turns a synchronised button level plus the upstream long-press level into
// single-cycle short/double/long/repeat event pulses. Auto-repeat is built only when PRESS_REPEAT_EN is defined.
//
// state    | meaning
// IDLE     | button released, no press in progress
// PRESSED  | first press in progress
// GAP      | first press released, waiting to see if a second press follows
// PRESSED2 | second press in progress
// HELD     | long press reached, waiting for release (repeats if enabled)
module press_event_decoder #(
  parameter int CLK_PERIOD_ns = 20,
  parameter int GAP_ns        = 300,
  parameter int REPEAT_ns     = 200
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  input  logic long_held,
  output logic short_pulse,
  output logic double_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic held
);

  localparam int GAP_RAW    = GAP_ns / CLK_PERIOD_ns;
  localparam int GAP_CYCLES = (GAP_RAW < 1) ? 1 : GAP_RAW;
  localparam int GAP_W      = $clog2(GAP_CYCLES) + 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

`ifdef PRESS_REPEAT_EN
  localparam int REP_RAW    = REPEAT_ns / CLK_PERIOD_ns;
  localparam int REP_CYCLES = (REP_RAW < 1) ? 1 : REP_RAW;
  localparam int REP_W      = $clog2(REP_CYCLES) + 1;
  localparam logic [REP_W-1:0] REP_LOAD = REP_W'(REP_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRESSED  = 3'd1,
    GAP      = 3'd2,
    PRESSED2 = 3'd3,
    HELD     = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_nxt;
  logic             short_nxt, double_nxt, long_nxt;

`ifdef PRESS_REPEAT_EN
  logic [REP_W-1:0] rep_cnt, rep_cnt_nxt;
  logic             repeat_nxt;
`endif

  // A released button always beats a trailing long_held, which lags btn by one cycle.
  always_comb begin
    state_nxt   = state;
    gap_cnt_nxt = gap_cnt;
    short_nxt   = 1'b0;
    double_nxt  = 1'b0;
    long_nxt    = 1'b0;
`ifdef PRESS_REPEAT_EN
    rep_cnt_nxt = rep_cnt;
    repeat_nxt  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (btn) state_nxt = PRESSED;
      end
      PRESSED: begin
        if (!btn) begin
          state_nxt   = GAP;
          gap_cnt_nxt = GAP_LOAD;
        end else if (long_held) begin
          state_nxt   = HELD;
          long_nxt    = 1'b1;
`ifdef PRESS_REPEAT_EN
          rep_cnt_nxt = REP_LOAD;
`endif
        end
      end
      GAP: begin
        if (btn) begin
          state_nxt = PRESSED2;
        end else if (gap_cnt == '0) begin
          state_nxt = IDLE;
          short_nxt = 1'b1;
        end else begin
          gap_cnt_nxt = gap_cnt - 1'b1;
        end
      end
      PRESSED2: begin
        if (!btn) begin
          state_nxt  = IDLE;
          double_nxt = 1'b1;
        end else if (long_held) begin
          // First press already completed as a short one; this one is the long press.
          state_nxt   = HELD;
          short_nxt   = 1'b1;
          long_nxt    = 1'b1;
`ifdef PRESS_REPEAT_EN
          rep_cnt_nxt = REP_LOAD;
`endif
        end
      end
      HELD: begin
        if (!btn) begin
          state_nxt = IDLE;
        end
`ifdef PRESS_REPEAT_EN
        else if (rep_cnt == '0) begin
          repeat_nxt  = 1'b1;
          rep_cnt_nxt = REP_LOAD;
        end else begin
          rep_cnt_nxt = rep_cnt - 1'b1;
        end
`endif
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      gap_cnt      <= '0;
      short_pulse  <= 1'b0;
      double_pulse <= 1'b0;
      long_pulse   <= 1'b0;
    end else begin
      state        <= state_nxt;
      gap_cnt      <= gap_cnt_nxt;
      short_pulse  <= short_nxt;
      double_pulse <= double_nxt;
      long_pulse   <= long_nxt;
    end
  end

`ifdef PRESS_REPEAT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rep_cnt      <= '0;
      repeat_pulse <= 1'b0;
    end else begin
      rep_cnt      <= rep_cnt_nxt;
      repeat_pulse <= repeat_nxt;
    end
  end
`else
  assign repeat_pulse = 1'b0;
`endif

  assign held = (state == HELD);

endmodule

// File: tb/tb_press_event_decoder.sv
// Directed bench for press_event_decoder at default parameters (GAP_CYCLES=15, REPEAT_CYCLES=10).
// Output vector order throughout: {short, double, long, repeat, held}.
module tb_press_event_decoder;

  logic clk = 1'b0;
  logic reset;
  logic btn;
  logic long_held;
  logic short_pulse, double_pulse, long_pulse, repeat_pulse, held;

  int total = 0;
  int bad   = 0;

`ifdef PRESS_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  press_event_decoder dut (
    .clk          (clk),
    .reset        (reset),
    .btn          (btn),
    .long_held    (long_held),
    .short_pulse  (short_pulse),
    .double_pulse (double_pulse),
    .long_pulse   (long_pulse),
    .repeat_pulse (repeat_pulse),
    .held         (held)
  );

  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [4:0] obs;
    reset = 1'b1; btn = 1'b0; long_held = 1'b0;
    tick(); tick();
    obs = {short_pulse, double_pulse, long_pulse, repeat_pulse, held};
    total++;
    if (obs !== 5'b0) begin
      bad++; $display("FAIL reset_hold got=%b want=%b", obs, 5'b0);
    end
    reset = 1'b0;
    tick(); tick();
    obs = {short_pulse, double_pulse, long_pulse, repeat_pulse, held};
    total++;
    if (obs !== 5'b0) begin
      bad++; $display("FAIL reset_idle got=%b want=%b", obs, 5'b0);
    end
  endtask

  // Release sampled at edge 5, short fires 15 edges later.
  task automatic test_short();
    logic [4:0] obs, exp;
    for (int c = 0; c < 24; c++) begin
      btn = (c < 5); long_held = 1'b0;
      tick();
      exp = {(c == 20), 4'b0};
      obs = {short_pulse, double_pulse, long_pulse, repeat_pulse, held};
      total++;
      if (obs !== exp) begin
        bad++; $display("FAIL short c=%0d got=%b want=%b", c, obs, exp);
      end
    end
  endtask

  task automatic test_double();
    logic [4:0] obs, exp;
    for (int c = 0; c < 40; c++) begin
      btn = (c < 5) || (c >= 13 && c < 18); long_held = 1'b0;
      tick();
      exp = {1'b0, (c == 18), 3'b0};
      obs = {short_pulse, double_pulse, long_pulse, repeat_pulse, held};
      total++;
      if (obs !== exp) begin
        bad++; $display("FAIL double c=%0d got=%b want=%b", c, obs, exp);
      end
    end
  endtask

  task automatic test_gap_boundary();
    logic [4:0] obs, exp;
    // Re-press lands on the expiry edge (20): PRESSED2 wins, release gives double.
    for (int c = 0; c < 30; c++) begin
      btn = (c < 5) || (c >= 20 && c < 25); long_held = 1'b0;
      tick();
      exp = {1'b0, (c == 25), 3'b0};
      obs = {short_pulse, double_pulse, long_pulse, repeat_pulse, held};
      total++;
      if (obs !== exp) begin
        bad++; $display("FAIL gap_edge c=%0d got=%b want=%b", c, obs, exp);
      end
    end
    // One cycle longer: short at 20, next press is a fresh first press.
    for (int c = 0; c < 45; c++) begin
      btn = (c < 5) || (c >= 21 && c < 26); long_held = 1'b0;
      tick();
      exp = {(c == 20) || (c == 41), 4'b0};
      obs = {short_pulse, double_pulse, long_pulse, repeat_pulse, held};
      total++;
      if (obs !== exp) begin
        bad++; $display("FAIL gap_over c=%0d got=%b want=%b", c, obs, exp);
      end
    end
  endtask

  task automatic test_long_repeat();
    logic [4:0] obs, exp;
    logic rep;
    for (int c = 0; c < 70; c++) begin
      btn = (c <= 60); long_held = (c >= 25 && c <= 61);
      tick();
      rep = REP_EN && (c == 35 || c == 45 || c == 55);
      exp = {1'b0, 1'b0, (c == 25), rep, (c >= 25 && c <= 60)};
      obs = {short_pulse, double_pulse, long_pulse, repeat_pulse, held};
      total++;
      if (obs !== exp) begin
        bad++; $display("FAIL long_repeat c=%0d got=%b want=%b", c, obs, exp);
      end
    end
  endtask

  task automatic test_second_long();
    logic [4:0] obs, exp;
    for (int c = 0; c < 30; c++) begin
      btn = (c < 5) || (c >= 10 && c <= 20); long_held = (c >= 15 && c <= 21);
      tick();
      exp = {(c == 15), 1'b0, (c == 15), 1'b0, (c >= 15 && c <= 20)};
      obs = {short_pulse, double_pulse, long_pulse, repeat_pulse, held};
      total++;
      if (obs !== exp) begin
        bad++; $display("FAIL second_long c=%0d got=%b want=%b", c, obs, exp);
      end
    end
  endtask

  task automatic test_reset_mid_held();
    logic [4:0] obs, exp;
    for (int c = 0; c < 7; c++) begin
      btn = 1'b1; long_held = (c >= 3);
      tick();
    end
    obs = {short_pulse, double_pulse, long_pulse, repeat_pulse, held};
    total++;
    if (obs !== 5'b00001) begin
      bad++; $display("FAIL pre_reset_held got=%b want=%b", obs, 5'b00001);
    end
    #3 reset = 1'b1;
    #2;
    obs = {short_pulse, double_pulse, long_pulse, repeat_pulse, held};
    total++;
    if (obs !== 5'b0) begin
      bad++; $display("FAIL async_reset got=%b want=%b", obs, 5'b0);
    end
    long_held = 1'b0;
    tick(); tick();
    reset = 1'b0;
    for (int c = 0; c < 12; c++) begin
      btn = (c < 8); long_held = (c >= 5 && c <= 8);
      tick();
      exp = {1'b0, 1'b0, (c == 5), 1'b0, (c >= 5 && c <= 7)};
      obs = {short_pulse, double_pulse, long_pulse, repeat_pulse, held};
      total++;
      if (obs !== exp) begin
        bad++; $display("FAIL after_reset c=%0d got=%b want=%b", c, obs, exp);
      end
    end
  endtask

  initial begin
    reset = 1'b1; btn = 1'b0; long_held = 1'b0;
    test_reset();
    test_short();
    test_double();
    test_gap_boundary();
    test_long_repeat();
    test_second_long();
    test_reset_mid_held();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
